// File: rtl/sa_pkg.sv
// Shared state encoding, select codes and default sizing for the systolic-array sequencer.
package sa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD_W,
    ST_LOAD_F,
    ST_CFG,
    ST_PRELOAD,
    ST_COMPUTE,
    ST_DONE
  } sa_state_e;

  localparam logic [1:0] SA_SEL_WEIGHT  = 2'd0;
  localparam logic [1:0] SA_SEL_FEATURE = 2'd1;
  localparam logic [1:0] SA_SEL_CONFIG  = 2'd2;

  localparam int SA_DIM            = 4;
  localparam int SA_DATA_W         = 8;
  localparam int SA_PRELOAD_CYCLES = 4;
  localparam int SA_COMPUTE_CYCLES = 22;

  function automatic int sa_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sa_sequencer_if.sv
// Host byte stream plus array load/enable port; master is the sequencer side.
interface sa_sequencer_if
  import sa_pkg::*;
#(
  parameter int DATA_W = SA_DATA_W,
  parameter int ADDR_W = 4
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              sa_reset;
  logic              sa_we;
  logic              sa_ena;
  logic [1:0]        sa_sel;
  logic [ADDR_W-1:0] sa_addr;
  logic [DATA_W-1:0] sa_data;

  modport master (
    input  s_valid, s_data,
    output s_ready, sa_reset, sa_we, sa_ena, sa_sel, sa_addr, sa_data
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, sa_reset, sa_we, sa_ena, sa_sel, sa_addr, sa_data
  );
endinterface

// File: rtl/sa_phase_counter.sv
// Loadable down-counter with terminal-count flag; used for beat and phase-cycle counts.
module sa_phase_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             tc
);
  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && !tc) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == '0);
endmodule

// File: rtl/sa_sequencer.sv
// One-start job controller for the 4x4 systolic array: clear, load, configure, run, done.
// Optional SA_SEQ_WEIGHT_REUSE_EN adds keep_w to skip the weight load and the array clear.
module sa_sequencer
  import sa_pkg::*;
#(
  parameter int DATA_W         = SA_DATA_W,
  parameter int DIM            = SA_DIM,
  parameter int PRELOAD_CYCLES = SA_PRELOAD_CYCLES,
  parameter int COMPUTE_CYCLES = SA_COMPUTE_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
`ifdef SA_SEQ_WEIGHT_REUSE_EN
  input  logic              keep_w,
`endif
  input  logic [DATA_W-1:0] act_cfg,
  output logic              busy,
  output logic              done,
  sa_sequencer_if.master    bus
);
  localparam int BEATS  = DIM * DIM;
  localparam int ADDR_W = $clog2(BEATS);
  localparam int CNT_W  = $clog2(sa_max3(BEATS, PRELOAD_CYCLES, COMPUTE_CYCLES));
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRELOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(COMPUTE_CYCLES - 1);

  sa_state_e         state_reg, state_next;
  logic              aborting_reg, aborting_next;
  logic              keep_reg, keep_next, keep_w_in;
  logic [DATA_W-1:0] act_cfg_reg;
  logic              cnt_load, cnt_dec, cnt_tc;
  logic [CNT_W-1:0]  cnt_load_val, cnt_value;
  logic              busy_reg, done_reg, clear_reg, ready_reg, ena_reg, cfg_reg;
  logic              busy_next, done_next, clear_next, ready_next, ena_next, cfg_next;
  logic [1:0]        sel_reg, sel_next;

`ifdef SA_SEQ_WEIGHT_REUSE_EN
  assign keep_w_in = keep_w;
`else
  assign keep_w_in = 1'b0;
`endif

  sa_phase_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_value),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_next    = state_reg;
    aborting_next = aborting_reg;
    keep_next     = keep_reg;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    cnt_dec       = 1'b0;
    if (state_reg != ST_IDLE && abort) begin
      state_next    = ST_CLR;
      aborting_next = 1'b1;
    end else begin
      unique case (state_reg)
        ST_IDLE: if (start && !abort) begin
          state_next = ST_CLR;
          keep_next  = keep_w_in;
        end
        // An abort-triggered CLR always falls back to IDLE.
        ST_CLR: begin
          cnt_load      = 1'b1;
          cnt_load_val  = BEAT_LAST;
          aborting_next = 1'b0;
          if (aborting_reg)  state_next = ST_IDLE;
          else if (keep_reg) state_next = ST_LOAD_F;
          else               state_next = ST_LOAD_W;
        end
        ST_LOAD_W, ST_LOAD_F: if (bus.s_valid) begin
          if (cnt_tc) begin
            cnt_load     = 1'b1;
            cnt_load_val = BEAT_LAST;
            state_next   = (state_reg == ST_LOAD_W) ? ST_LOAD_F : ST_CFG;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_CFG: begin
          cnt_load     = 1'b1;
          cnt_load_val = PRE_LAST;
          state_next   = ST_PRELOAD;
        end
        ST_PRELOAD: if (cnt_tc) begin
          cnt_load     = 1'b1;
          cnt_load_val = COMP_LAST;
          state_next   = ST_COMPUTE;
        end else begin
          cnt_dec = 1'b1;
        end
        ST_COMPUTE: if (cnt_tc) state_next = ST_DONE;
                    else        cnt_dec    = 1'b1;
        ST_DONE:    state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Output flags are decoded from the next state so they leave the flops aligned with it.
  always_comb begin
    busy_next  = (state_next != ST_IDLE);
    done_next  = (state_next == ST_DONE);
    clear_next = (state_next == ST_CLR) && (aborting_next || !keep_next);
    ready_next = (state_next == ST_LOAD_W) || (state_next == ST_LOAD_F);
    ena_next   = (state_next == ST_PRELOAD) || (state_next == ST_COMPUTE);
    cfg_next   = (state_next == ST_CFG);
    sel_next   = SA_SEL_WEIGHT;
    case (state_next)
      ST_LOAD_F:                       sel_next = SA_SEL_FEATURE;
      ST_CFG, ST_PRELOAD, ST_COMPUTE:  sel_next = SA_SEL_CONFIG;
      default:                         sel_next = SA_SEL_WEIGHT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      aborting_reg <= 1'b0;
      keep_reg     <= 1'b0;
      act_cfg_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      clear_reg    <= 1'b0;
      ready_reg    <= 1'b0;
      ena_reg      <= 1'b0;
      cfg_reg      <= 1'b0;
      sel_reg      <= SA_SEL_WEIGHT;
    end else begin
      state_reg    <= state_next;
      aborting_reg <= aborting_next;
      keep_reg     <= keep_next;
      if (state_reg == ST_IDLE && start && !abort) act_cfg_reg <= act_cfg;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      clear_reg    <= clear_next;
      ready_reg    <= ready_next;
      ena_reg      <= ena_next;
      cfg_reg      <= cfg_next;
      sel_reg      <= sel_next;
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign bus.s_ready  = ready_reg;
  assign bus.sa_reset = clear_reg;
  assign bus.sa_ena   = ena_reg;
  assign bus.sa_sel   = sel_reg;
  assign bus.sa_we    = ready_reg ? bus.s_valid : cfg_reg;
  assign bus.sa_data  = ready_reg ? bus.s_data : (cfg_reg ? act_cfg_reg : '0);
  assign bus.sa_addr  = ready_reg ? ADDR_W'(BEAT_LAST - cnt_value) : '0;
endmodule

// File: doc/sa_sequencer.md
# sa_sequencer

Sequencer for the 4×4 systolic-array datapath, sitting between a host byte stream and the array's load/enable port. One `start` pulse runs one job:
- clear the array;
- stream 16 weight bytes, then 16 feature bytes, into the array memories;
- write the activation configuration;
- run the preload and compute phases for fixed cycle counts;
- pulse `done`.

It replaces hand-driven `we`/`ena`/`sel`/`addr` stimulus with a single deterministic controller.

## Interface
- `DATA_W`, 8, array element and stream width
- `DIM`, 4, array dimension; memories hold DIM×DIM bytes
- `PRELOAD_CYCLES`, 4, cycles of `sa_ena` for weight preload
- `COMPUTE_CYCLES`, 22, cycles of `sa_ena` for multiply, drain and writeback
- `clk` in 1: single clock, all logic rising-edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: begin job; sampled only in IDLE
- `abort` in 1: cancel the current job
- `act_cfg` in DATA_W: activation configuration byte; latched on accepted `start`
- `keep_w` in 1: skip weight load; present only with `SA_SEQ_WEIGHT_REUSE_EN`
- `s_valid` in 1 / `s_data` in DATA_W / `s_ready` out 1: host byte stream, weights first then features
- `busy` out 1: job in progress (any state except IDLE)
- `done` out 1: one-cycle pulse on job completion
- `sa_reset` out 1: active-high clear to the array
- `sa_we`, `sa_ena` out 1: write enable and run enable to the array
- `sa_sel` out 2: target select; 0 = weight, 1 = feature, 2 = config
- `sa_addr` out 4: byte address within the selected memory
- `sa_data` out DATA_W: write data to the array

## Operation

States, in order: IDLE → CLR → LOAD_W → LOAD_F → CFG → PRELOAD → COMPUTE → DONE → IDLE.

- **IDLE**
  - All array outputs 0; `s_ready` = 0.
  - `start` = 1 latches `act_cfg` and moves to CLR.
- **CLR** (1 cycle)
  - `sa_reset` = 1.
  - Beat counter cleared.
- **LOAD_W, LOAD_F**
  - `s_ready` = 1.
  - `sa_sel` = 0 in LOAD_W, 1 in LOAD_F.
  - `sa_we` = `s_valid`, `sa_data` = `s_data`, `sa_addr` = beat counter.
  - Counter increments on each accepted beat (`s_valid` && `s_ready`).
  - When `s_valid` = 0: `sa_we` = 0 and the address holds.
  - Accepted beat 15 advances the state and wraps the counter to 0.
- **CFG** (1 cycle)
  - `sa_sel` = 2, `sa_we` = 1, `sa_data` = latched `act_cfg`, `sa_addr` = 0.
  - `s_ready` = 0.
- **PRELOAD**
  - `sa_ena` = 1, `sa_we` = 0, `sa_sel` = 2, for exactly `PRELOAD_CYCLES` cycles.
- **COMPUTE**
  - `sa_ena` = 1 for exactly `COMPUTE_CYCLES` cycles.
  - The array drives writeback memory itself; the sequencer does not read results.
- **DONE** (1 cycle)
  - `done` = 1, `sa_ena` = 0, then IDLE.

Boundary rules:
- `start` while `busy` is ignored.
- `abort` in any non-IDLE state: next cycle enters CLR, then returns to IDLE.
  - No `done` pulse; partial data is discarded.
- `abort` and `start` together in IDLE: `abort` wins and the sequencer stays in IDLE.
- A stream beat offered outside LOAD_W/LOAD_F is not accepted (`s_ready` = 0).

## Timing
- Reset values: every output 0; state IDLE; counters and latched config 0.
- All outputs are registered; there are no combinational paths from inputs to outputs except `sa_we` and `sa_data` during LOAD_W/LOAD_F.
- No-stall job length: 1 (CLR) + 16 + 16 + 1 (CFG) + 4 + 22 + 1 (DONE) = 61 cycles.
  - `start` accepted at edge N ⇒ `done` high in the cycle after edge N+61.
- Each stall cycle (`s_valid` = 0) adds one cycle.
- `reset_n` deassertion mid-job:
  - all outputs return to 0 asynchronously;
  - on release the sequencer sits in IDLE, with no `done` and no `sa_reset` pulse.

## Configuration
- `SA_SEQ_WEIGHT_REUSE_EN` defined:
  - `keep_w` port exists and is latched with `start`.
  - If `keep_w` = 1, CLR moves directly to LOAD_F and `sa_reset` is not asserted in CLR, so weights are preserved.
  - No-stall job length is then 45 cycles.
  - A job with `keep_w` = 1 after reset and before any full load is still executed; the result is undefined and this is not checked.
- Macro undefined: the `keep_w` port is absent and every job loads weights.

## Structure
- Shared package `sa_pkg`:
  - state enum;
  - `SA_SEL_WEIGHT`, `SA_SEL_FEATURE`, `SA_SEL_CONFIG` constants;
  - default `DIM`, `DATA_W`, `PRELOAD_CYCLES`, `COMPUTE_CYCLES`.
- One sub-module, `sa_phase_counter`: a loadable down-counter with terminal-count flag.
  - Shared by the beat count (DIM×DIM) and the PRELOAD/COMPUTE cycle counts.

## Test plan
- **Reset:** `reset_n` low → every output 0, state IDLE, `busy` = 0.
- **Full job, no stalls:** matrix A rows = {1,2,3,4}×4, B = {4,0,2,1},{4,3,2,0},{4,3,0,1},{4,3,2,1}, `act_cfg` = 0x0A →
  - `sa_sel` / `sa_addr` sequence is 0/0..15, then 1/0..15, then 2;
  - `sa_ena` high for 26 cycles;
  - `done` exactly 61 cycles after `start`;
  - writeback memory row 0 = 0x14131619 per array semantics.
- **Stalls:** drop `s_valid` on every other beat during both loads →
  - no address skipped or repeated;
  - `done` at 61 + 32 cycles.
- **Abort:** `abort` mid-LOAD_F (beat 7) → one `sa_reset` cycle, then IDLE, no `done`; a following full job completes correctly.
- **Start while busy:** second `start` during COMPUTE → ignored; exactly one `done`.
- **Weight reuse (macro on):** `keep_w` = 1 second job → no `sa_reset`, no LOAD_W beats, `done` at 45 cycles.
